vga_mem_arbiter: RTL and testbench

Arbitrates a single-port synchronous pixel memory between the VGA scanout path and a drawing-engine writer. Sits between `vga_sync` (which supplies x, y, nblanc and the 25 MHz pixel enable), the framebuffer RAM and the game/draw logic. Scanout reads always win on pixel-enable cycles; the writer is served on every other cycle through a req/ack handshake. Each scanout read is converted into a registered pixel colour for the DAC.

---
 rtl/vga_mem_arbiter.sv | 107 ++++++++++
 tb/tb_vga_mem_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/vga_mem_arbiter.sv
// Single-port framebuffer arbiter: scanout reads win on visible pixel-enable cycles, the writer gets the rest.
// Define VGA_ARB_BLANK_ONLY_EN to restrict writes to the blanking interval (tear-free updates).
module vga_mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              nblanc,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} st_t;

  localparam int unsigned FB_WORDS = H_RES * V_RES;

  st_t               st, st_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              we_nxt, ack_nxt, err_set;
  logic              in_range, write_ok;
  logic              blank_p0;
  logic              vld_p1, blank_p1;

  function automatic logic [ADDR_W-1:0] scan_addr(input logic [9:0] col, input logic [9:0] row);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    if (H_RES == 640) return (r << 9) + (r << 7) + ADDR_W'(col);
    else              return r * ADDR_W'(H_RES) + ADDR_W'(col);
  endfunction

  assign in_range = (32'(wr_addr) < FB_WORDS);

`ifdef VGA_ARB_BLANK_ONLY_EN
  assign write_ok = !nblanc;
`else
  assign write_ok = 1'b1;
`endif

  always_comb begin
    st_nxt    = IDLE;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    we_nxt    = 1'b0;
    ack_nxt   = 1'b0;
    err_set   = 1'b0;
    if (pix_en && nblanc) begin
      st_nxt   = READ;
      addr_nxt = scan_addr(x, y);
    end else if (wr_req && write_ok) begin
      // Out-of-range writes are still acked so the writer never stalls; only the strobe is suppressed.
      st_nxt    = WRITE;
      addr_nxt  = wr_addr;
      wdata_nxt = wr_data;
      we_nxt    = in_range;
      ack_nxt   = 1'b1;
      err_set   = !in_range;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      blank_p0  <= 1'b0;
      vld_p1    <= 1'b0;
      blank_p1  <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      // p0: access presented on the memory port (READ state or blank token)
      st        <= st_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_we    <= we_nxt;
      wr_ack    <= ack_nxt;
      wr_err    <= wr_err | err_set;
      blank_p0  <= pix_en && !nblanc;
      // p1: RAM is sampling the read address
      vld_p1    <= (st == READ) || blank_p0;
      blank_p1  <= blank_p0;
      // p2: capture RAM data (or black for blanking) toward the DAC
      pix_valid <= vld_p1;
      if (vld_p1) pix_data <= blank_p1 ? '0 : mem_rdata;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: reset, scanout, write collision, range check, blanking, async reset.
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        nblanc = 1'b0;
  logic        wr_req = 1'b0;
  logic [18:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_ack, wr_err, mem_we, pix_valid;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata, pix_data;
  logic [7:0]  mem_rdata = 8'h00;

  int total = 0;
  int bad = 0;
  int activity;

  always #10 clk = ~clk;

  vga_mem_arbiter dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .nblanc(nblanc),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  // Synchronous RAM stand-in: one word holds A5, everything else reads 5A.
  always @(posedge clk) mem_rdata <= (mem_addr == 19'd1285) ? 8'hA5 : 8'h5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 19'd0);
    chk("rst_ack", wr_ack, 1'b0);
    chk("rst_pix", pix_data, 8'h00);
    reset = 1'b0;

    // idle for 100 cycles
    activity = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_we || wr_ack || pix_valid || wr_err) activity++;
    end
    chk("idle_quiet", activity, 0);
    chk("idle_st", dut.st, 2'd0);
    chk("idle_wdata", mem_wdata, 8'h00);

    // visible scanout read at (5,2)
    x = 10'd5; y = 10'd2; nblanc = 1'b1; pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("rd_addr", mem_addr, 19'd1285);
    chk("rd_we", mem_we, 1'b0);
    chk("rd_st", dut.st, 2'd1);
    chk("rd_valid_e0", pix_valid, 1'b0);
    tick();
    chk("rd_valid_e1", pix_valid, 1'b0);
    tick();
    chk("rd_valid_e2", pix_valid, 1'b1);
    chk("rd_data_e2", pix_data, 8'hA5);
    tick();
    chk("rd_valid_drop", pix_valid, 1'b0);

    // write arriving together with a visible read
    pix_en = 1'b1; wr_req = 1'b1; wr_addr = 19'd1000; wr_data = 8'h3C;
    tick();
    pix_en = 1'b0;
    chk("col_read_addr", mem_addr, 19'd1285);
    chk("col_ack0", wr_ack, 1'b0);
    chk("col_we0", mem_we, 1'b0);
`ifdef VGA_ARB_BLANK_ONLY_EN
    tick();
    chk("bo_hold_ack", wr_ack, 1'b0);
    tick();
    chk("bo_hold_ack2", wr_ack, 1'b0);
    nblanc = 1'b0;
    tick();
    wr_req = 1'b0;
    chk("bo_ack", wr_ack, 1'b1);
    chk("bo_we", mem_we, 1'b1);
    chk("bo_addr", mem_addr, 19'd1000);
    chk("bo_wdata", mem_wdata, 8'h3C);
    tick();
`else
    tick();
    wr_req = 1'b0;
    chk("col_ack1", wr_ack, 1'b1);
    chk("col_we1", mem_we, 1'b1);
    chk("col_addr1", mem_addr, 19'd1000);
    chk("col_wdata1", mem_wdata, 8'h3C);
    chk("col_st1", dut.st, 2'd2);
    tick();
    chk("col_ack_drop", wr_ack, 1'b0);
    chk("col_we_drop", mem_we, 1'b0);
    chk("col_pix_valid", pix_valid, 1'b1);
    chk("col_pix_data", pix_data, 8'hA5);
    chk("col_err", wr_err, 1'b0);
`endif

    // range boundary: last word is legal, first word past the frame is not
    nblanc = 1'b0;
    wr_req = 1'b1; wr_addr = 19'd307200; wr_data = 8'hFF;
    tick();
    wr_req = 1'b0;
    chk("oor_ack", wr_ack, 1'b1);
    chk("oor_we", mem_we, 1'b0);
    chk("oor_err", wr_err, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk("oor_err_sticky", wr_err, 1'b1);
    chk("oor_ack_drop", wr_ack, 1'b0);
    wr_req = 1'b1; wr_addr = 19'd307199; wr_data = 8'h11;
    tick();
    wr_req = 1'b0;
    chk("last_we", mem_we, 1'b1);
    chk("last_addr", mem_addr, 19'd307199);
    chk("last_err_kept", wr_err, 1'b1);
    tick();

    // blanking token yields black even though RAM returns 5A
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("blk_st", dut.st, 2'd0);
    chk("blk_we", mem_we, 1'b0);
    chk("blk_addr_held", mem_addr, 19'd307199);
    tick();
    chk("blk_valid_e1", pix_valid, 1'b0);
    tick();
    chk("blk_valid_e2", pix_valid, 1'b1);
    chk("blk_data", pix_data, 8'h00);

    // reload A5 into pix_data, then reset during a pending write
    x = 10'd5; y = 10'd2; nblanc = 1'b1; pix_en = 1'b1;
    tick();
    pix_en = 1'b0; nblanc = 1'b0;
    tick(); tick();
    chk("pre_rst_pix", pix_data, 8'hA5);
    wr_req = 1'b1; wr_addr = 19'd2000; wr_data = 8'h77;
    #4 reset = 1'b1;
    #1;
    chk("arst_we", mem_we, 1'b0);
    chk("arst_ack", wr_ack, 1'b0);
    chk("arst_pix", pix_data, 8'h00);
    chk("arst_addr", mem_addr, 19'd0);
    chk("arst_err", wr_err, 1'b0);
    tick();
    chk("arst_we_edge", mem_we, 1'b0);
    chk("arst_ack_edge", wr_ack, 1'b0);
    wr_req = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_we", mem_we, 1'b0);
    chk("post_rst_st", dut.st, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
